// File: rtl/bus_master_pkg.sv
// Shared types for the 8088 bus master: FSM states, bus cycle kinds, default wait limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_master_pkg;

  // Consecutive wait states tolerated before a cycle is aborted with an error.
  localparam int WAIT_LIMIT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_TW   = 3'd4,
    ST_T4   = 3'd5
  } state_t;

  // Encoded as {io, write} so the two bus attributes can be sliced straight out.
  typedef enum logic [1:0] {
    MEM_RD = 2'b00,
    MEM_WR = 2'b01,
    IO_RD  = 2'b10,
    IO_WR  = 2'b11
  } cycle_t;

  function automatic cycle_t make_cycle(input logic io, input logic write);
    return cycle_t'({io, write});
  endfunction

  function automatic logic cycle_is_write(input cycle_t c);
    return c[0];
  endfunction

  function automatic logic cycle_is_io(input cycle_t c);
    return c[1];
  endfunction

endpackage

// File: rtl/bus_master_8088.sv
// 8088-style bus master: turns one request into a T1..T4 bus cycle with READY wait states.
// Latency: 4 cycles from acceptance to rsp_valid, +1 per wait state; aborted after WAIT_LIMIT waits.
// Backpressure: req_ready only in IDLE/T4; a request accepted in T4 starts T1 back-to-back.
module bus_master_8088
  import bus_master_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic [11:0] A,
  output logic [7:0]  AD_OUT,
  output logic        AD_OE,
  input  logic [7:0]  AD_IN,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        DEN,
  output logic        IOM,
  output logic        DTR,
  input  logic        READY
);

  // Counter must hold WAIT_LIMIT itself; keep at least one bit for a zero limit.
  localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  // The shared AD pins are driven at chip level as AD_OE ? AD_OUT : 'z.

  state_t        state, state_nx;
  cycle_t        cyc_q, cyc_cur;
  logic [19:0]   addr_q, addr_cur;
  logic [7:0]    wdata_q, wdata_cur;
  logic [CW-1:0] wait_cnt;
  logic          accept;
  logic          in_wait;
  logic          abort;
  logic          cur_write;

  assign accept  = req_valid & req_ready;
  assign in_wait = (state == ST_T3) || (state == ST_TW);
  // wait_cnt is zero in T3, so this also covers a limit of zero.
  assign abort   = in_wait & ~READY & (wait_cnt == CW'(WAIT_LIMIT));

  // Request fields seen by the next bus state: fresh ones on acceptance, captured ones otherwise.
  always_comb begin
    cyc_cur   = cyc_q;
    addr_cur  = addr_q;
    wdata_cur = wdata_q;
    if (accept) begin
      cyc_cur   = make_cycle(req_io, req_write);
      addr_cur  = req_addr;
      wdata_cur = req_wdata;
    end
  end

  assign cur_write = cycle_is_write(cyc_cur);

  // Bus cycle sequencing; READY only matters while in T3/TW.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = accept ? ST_T1 : ST_IDLE;
      ST_T1:        state_nx = ST_T2;
      ST_T2:        state_nx = ST_T3;
      ST_T3, ST_TW: state_nx = (READY || abort) ? ST_T4 : ST_TW;
      ST_T4:        state_nx = accept ? ST_T1 : ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // State register and request capture at acceptance.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cyc_q   <= MEM_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cyc_q   <= cyc_cur;
        addr_q  <= addr_cur;
        wdata_q <= wdata_cur;
      end
    end
  end

  // Count consecutive wait states; cleared whenever the cycle leaves T3/TW.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wait_cnt <= '0;
    end else if (in_wait && !READY && !abort) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Bus pins registered from the state being entered, so they line up with that state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ALE    <= 1'b0;
      RD     <= 1'b1;
      WR     <= 1'b1;
      DEN    <= 1'b1;
      AD_OE  <= 1'b0;
      DTR    <= 1'b0;
      IOM    <= 1'b0;
      A      <= '0;
      AD_OUT <= '0;
    end else begin
      case (state_nx)
        ST_T1: begin
          ALE    <= 1'b1;
          A      <= addr_cur[19:8];
          AD_OUT <= addr_cur[7:0];
          AD_OE  <= 1'b1;
          IOM    <= cycle_is_io(cyc_cur);
          DTR    <= cur_write;
          RD     <= 1'b1;
          WR     <= 1'b1;
          DEN    <= 1'b1;
        end
        ST_T2, ST_T3, ST_TW: begin
          ALE <= 1'b0;
          DEN <= 1'b0;
          if (cur_write) begin
            AD_OE  <= 1'b1;
            AD_OUT <= wdata_cur;
            WR     <= 1'b0;
            RD     <= 1'b1;
          end else begin
            AD_OE <= 1'b0;
            RD    <= 1'b0;
            WR    <= 1'b1;
          end
        end
        ST_T4: begin
          ALE   <= 1'b0;
          RD    <= 1'b1;
          WR    <= 1'b1;
          DEN   <= 1'b1;
          AD_OE <= cur_write;
        end
        default: begin
          ALE   <= 1'b0;
          RD    <= 1'b1;
          WR    <= 1'b1;
          DEN   <= 1'b1;
          AD_OE <= 1'b0;
        end
      endcase
    end
  end

  // Handshake and response; rsp_rdata/rsp_err only change on the edge entering T4.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      req_ready <= (state_nx == ST_IDLE) || (state_nx == ST_T4);
      rsp_valid <= (state_nx == ST_T4);
      if (in_wait && (state_nx == ST_T4)) begin
        if (abort) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end else begin
          rsp_err   <= 1'b0;
          rsp_rdata <= cur_write ? 8'h00 : AD_IN;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_master_8088.sv
// Directed bench for bus_master_8088: reset, read/write cycles, waits, back-to-back, abort, mid-cycle reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requests are held until req_ready accepts them.
module tb_bus_master_8088;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [11:0] A;
    logic [7:0]  AD_OUT;
    logic        AD_OE;
    logic [7:0]  AD_IN;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        DEN;
    logic        IOM;
    logic        DTR;
    logic        READY;

    int checks = 0;
    int errors = 0;
    int n;
    logic prev_vld = 1'b0;

    bus_master_8088 #(.WAIT_LIMIT(15)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_io(req_io),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .A(A), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .AD_IN(AD_IN),
        .ALE(ALE), .RD(RD), .WR(WR), .DEN(DEN), .IOM(IOM), .DTR(DTR), .READY(READY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input bit ok, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus protocol invariants sampled mid-cycle while out of reset.
    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            chk("rd_wr_exclusive", (RD | WR) === 1'b1, (RD | WR), 1'b1);
            chk("ale_den_exclusive", (ALE & ~DEN) === 1'b0, (ALE & ~DEN), 1'b0);
            chk("rsp_single_pulse", (rsp_valid & prev_vld) === 1'b0, (rsp_valid & prev_vld), 1'b0);
        end
        prev_vld = rsp_valid;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
        req_addr = '0; req_wdata = '0; AD_IN = '0; READY = 1'b0;

        // Reset values
        repeat (2) tick();
        chk("reset_ctl", {ALE, RD, WR, DEN, AD_OE, DTR, IOM} === 7'b0111000, {ALE, RD, WR, DEN, AD_OE, DTR, IOM}, 7'b0111000);
        chk("reset_A", A === 12'h000, A, 12'h000);
        chk("reset_AD_OUT", AD_OUT === 8'h00, AD_OUT, 8'h00);
        chk("reset_ready", req_ready === 1'b0, req_ready, 1'b0);
        chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata} === 10'h000, {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
        @(negedge CLK) RESET = 1'b1;
        tick();
        chk("ready_after_reset", req_ready === 1'b1, req_ready, 1'b1);

        // Memory read 0x80005, READY=1, returns 0x3C
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h80005; READY = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("mr_t1_ctl", {ALE, AD_OE, IOM, DTR, RD, WR, DEN} === 7'b1100111, {ALE, AD_OE, IOM, DTR, RD, WR, DEN}, 7'b1100111);
        chk("mr_t1_A", A === 12'h800, A, 12'h800);
        chk("mr_t1_AD", AD_OUT === 8'h05, AD_OUT, 8'h05);
        chk("mr_t1_ready", req_ready === 1'b0, req_ready, 1'b0);
        tick();
        chk("mr_t2_ctl", {ALE, AD_OE, RD, WR, DEN} === 5'b00010, {ALE, AD_OE, RD, WR, DEN}, 5'b00010);
        chk("mr_t2_A", A === 12'h800, A, 12'h800);
        AD_IN = 8'h3C;
        tick();
        chk("mr_t3_vld", rsp_valid === 1'b0, rsp_valid, 1'b0);
        tick();
        chk("mr_t4_vld", rsp_valid === 1'b1, rsp_valid, 1'b1);
        chk("mr_t4_rdata", rsp_rdata === 8'h3C, rsp_rdata, 8'h3C);
        chk("mr_t4_err", rsp_err === 1'b0, rsp_err, 1'b0);
        chk("mr_t4_ctl", {RD, WR, DEN, ALE, AD_OE, req_ready} === 6'b111001, {RD, WR, DEN, ALE, AD_OE, req_ready}, 6'b111001);
        AD_IN = 8'h00;
        tick();
        chk("mr_idle_vld", rsp_valid === 1'b0, rsp_valid, 1'b0);
        chk("mr_idle_rdata_held", rsp_rdata === 8'h3C, rsp_rdata, 8'h3C);

        // I/O write port 0xFF03, data 0xA5
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b1; req_addr = 20'h0FF03; req_wdata = 8'hA5;
        tick();
        req_valid = 1'b0; req_wdata = 8'h00;
        chk("iw_t1_ctl", {ALE, AD_OE, IOM, DTR, RD, WR, DEN} === 7'b1111111, {ALE, AD_OE, IOM, DTR, RD, WR, DEN}, 7'b1111111);
        chk("iw_t1_A", A === 12'h0FF, A, 12'h0FF);
        chk("iw_t1_AD", AD_OUT === 8'h03, AD_OUT, 8'h03);
        tick();
        chk("iw_t2_ctl", {ALE, AD_OE, IOM, DTR, RD, WR, DEN} === 7'b0111100, {ALE, AD_OE, IOM, DTR, RD, WR, DEN}, 7'b0111100);
        chk("iw_t2_AD", AD_OUT === 8'hA5, AD_OUT, 8'hA5);
        tick();
        chk("iw_t3_ctl", {ALE, AD_OE, RD, WR, DEN, rsp_valid} === 6'b011000, {ALE, AD_OE, RD, WR, DEN, rsp_valid}, 6'b011000);
        tick();
        chk("iw_t4_vld_err", {rsp_valid, rsp_err} === 2'b10, {rsp_valid, rsp_err}, 2'b10);
        chk("iw_t4_ctl", {RD, WR, DEN, AD_OE, ALE} === 5'b11110, {RD, WR, DEN, AD_OE, ALE}, 5'b11110);
        tick();

        // Memory read with two wait states
        READY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h12345;
        tick();
        req_valid = 1'b0;
        chk("ws_t1_A", A === 12'h123, A, 12'h123);
        tick();
        tick();
        tick();
        chk("ws_tw1", {RD, DEN, rsp_valid} === 3'b000, {RD, DEN, rsp_valid}, 3'b000);
        tick();
        chk("ws_tw2", {RD, DEN, rsp_valid} === 3'b000, {RD, DEN, rsp_valid}, 3'b000);
        READY = 1'b1; AD_IN = 8'h5A;
        tick();
        chk("ws_t4_vld", rsp_valid === 1'b1, rsp_valid, 1'b1);
        chk("ws_t4_rdata", rsp_rdata === 8'h5A, rsp_rdata, 8'h5A);
        chk("ws_t4_rd", RD === 1'b1, RD, 1'b1);
        tick();
        AD_IN = 8'h00;

        // Back-to-back: write 0x00100/0x11 then read 0xABCDE/0x77, request held valid
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b0; req_addr = 20'h00100; req_wdata = 8'h11;
        tick();
        chk("bb_t1a_A", A === 12'h001, A, 12'h001);
        req_write = 1'b0; req_addr = 20'hABCDE; req_wdata = 8'h00;
        tick();
        chk("bb_t2a_AD", AD_OUT === 8'h11, AD_OUT, 8'h11);
        chk("bb_t2a_wr", WR === 1'b0, WR, 1'b0);
        tick();
        AD_IN = 8'h77;
        tick();
        chk("bb_t4a", {rsp_valid, req_ready} === 2'b11, {rsp_valid, req_ready}, 2'b11);
        tick();
        req_valid = 1'b0;
        chk("bb_t1b_ctl", {ALE, DTR, rsp_valid} === 3'b100, {ALE, DTR, rsp_valid}, 3'b100);
        chk("bb_t1b_A", A === 12'hABC, A, 12'hABC);
        chk("bb_t1b_AD", AD_OUT === 8'hDE, AD_OUT, 8'hDE);
        tick();
        tick();
        chk("bb_t3b_vld", rsp_valid === 1'b0, rsp_valid, 1'b0);
        tick();
        chk("bb_t4b_vld", rsp_valid === 1'b1, rsp_valid, 1'b1);
        chk("bb_t4b_rdata", rsp_rdata === 8'h77, rsp_rdata, 8'h77);
        tick();
        chk("bb_idle", {req_ready, ALE, rsp_valid} === 3'b100, {req_ready, ALE, rsp_valid}, 3'b100);
        AD_IN = 8'h00;

        // READY stuck low: 15 wait states then abort
        READY = 1'b0; AD_IN = 8'hFF;
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h54321;
        tick();
        req_valid = 1'b0;
        n = 1;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_latency", n == 19, n, 19);
        chk("to_err", rsp_err === 1'b1, rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata === 8'h00, rsp_rdata, 8'h00);
        chk("to_rd_high", RD === 1'b1, RD, 1'b1);
        tick();
        AD_IN = 8'h00; READY = 1'b1;
        chk("to_err_held", {rsp_err, rsp_valid} === 2'b10, {rsp_err, rsp_valid}, 2'b10);

        // Reset asserted during T2 of a write
        req_valid = 1'b1; req_write = 1'b1; req_io = 1'b0; req_addr = 20'h20000; req_wdata = 8'h99;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rs_t2_ctl", {WR, DEN, AD_OE} === 3'b001, {WR, DEN, AD_OE}, 3'b001);
        #2 RESET = 1'b0;
        #1;
        chk("rs_async_ctl", {WR, DEN, AD_OE, RD, ALE} === 5'b11010, {WR, DEN, AD_OE, RD, ALE}, 5'b11010);
        chk("rs_async_rsp", {rsp_valid, rsp_err, req_ready} === 3'b000, {rsp_valid, rsp_err, req_ready}, 3'b000);
        repeat (2) tick();
        chk("rs_hold_vld", rsp_valid === 1'b0, rsp_valid, 1'b0);
        @(negedge CLK) RESET = 1'b1;
        tick();
        chk("rs_release", {req_ready, rsp_valid} === 2'b10, {req_ready, rsp_valid}, 2'b10);

        // Normal read after reset release
        req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 20'h00FF0;
        tick();
        req_valid = 1'b0;
        chk("pr_t1_ctl", {ALE, AD_OE, RD} === 3'b111, {ALE, AD_OE, RD}, 3'b111);
        chk("pr_t1_A", A === 12'h00F, A, 12'h00F);
        chk("pr_t1_AD", AD_OUT === 8'hF0, AD_OUT, 8'hF0);
        tick();
        tick();
        AD_IN = 8'hC3;
        tick();
        chk("pr_t4", {rsp_valid, rsp_err} === 2'b10, {rsp_valid, rsp_err}, 2'b10);
        chk("pr_rdata", rsp_rdata === 8'hC3, rsp_rdata, 8'hC3);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
